// File: rtl/g_inv_pkg.sv
// g_inv_pkg: red-channel response table, widths and search state encoding for g_red_inv
package g_inv_pkg;
    localparam int PIX_W = 5;
    localparam int LOG_W = 8;
    localparam logic [LOG_W-1:0] CRF_RED [32] = '{
        8'h00, 8'h09, 8'h10, 8'h15, 8'h18, 8'h1C, 8'h1F, 8'h21,
        8'h23, 8'h26, 8'h27, 8'h29, 8'h2B, 8'h2C, 8'h2E, 8'h30,
        8'h32, 8'h34, 8'h36, 8'h38, 8'h39, 8'h3B, 8'h3D, 8'h3E,
        8'h40, 8'h41, 8'h43, 8'h44, 8'h46, 8'h48, 8'h4B, 8'h51
    };
    typedef enum logic [2:0] {IDLE, SET, CMP, RSET, RCMP, DONE} state_t;
endpackage

// File: rtl/g_red_inv_if.sv
// g_red_inv_if: target request and pixel result handshakes of g_red_inv
interface g_red_inv_if;
    import g_inv_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [LOG_W-1:0] in_log;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    modport master (output in_valid, in_log, out_ready, input in_ready, out_valid, out_pixel);
    modport slave  (input in_valid, in_log, out_ready, output in_ready, out_valid, out_pixel);
endinterface

// File: rtl/g_red_inv_rom.sv
// g_red_inv_rom: registered 32-entry red response ROM, frozen while clk_en is low
module g_red_inv_rom
    import g_inv_pkg::*;
(
    input  logic             clk,
    input  logic             clk_en,
    input  logic [PIX_W-1:0] addr,
    output logic [LOG_W-1:0] q
);
    always_ff @(posedge clk)
        if (clk_en) q <= CRF_RED[addr];
endmodule

// File: rtl/g_red_inv.sv
// g_red_inv: binary search over the red response ROM for the code matching a log-exposure target
module g_red_inv
    import g_inv_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    g_red_inv_if.slave  bus
);
    state_t           state, nxt;
    logic [LOG_W-1:0] tgt, glo, rom_q;
    logic [PIX_W-1:0] res, pix, addr;
    logic [2:0]       k;
    logic             hit, up;

    g_red_inv_rom u_rom (.clk(clk), .clk_en(clk_en), .addr(addr), .q(rom_q));

    assign addr = (state == RSET) ? ((res == 5'd31) ? res : res + 5'd1) : (res | (5'd1 << k));
    assign hit  = rom_q <= tgt;
    // glo holds g(res) from the search, so rounding needs no second ROM read of res
    assign up   = (res != 5'd31) && (({1'b0, rom_q} - {1'b0, tgt}) < ({1'b0, tgt} - {1'b0, glo}));

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else if (clk_en) state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = bus.in_valid ? SET : IDLE;
            SET:  nxt = CMP;
            CMP:  nxt = (k != 3'd0) ? SET : (ROUND_NEAREST ? RSET : DONE);
            RSET: nxt = RCMP;
            RCMP: nxt = DONE;
            DONE: nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.out_pixel = (state == DONE) ? res : pix;
    end

    always_ff @(posedge clk)
        if (rst) begin
            tgt <= '0;
            glo <= '0;
            res <= '0;
            pix <= '0;
            k   <= '0;
        end else if (clk_en) begin
            if (state == IDLE && bus.in_valid) begin
                tgt <= bus.in_log;
                glo <= '0;
                res <= '0;
                k   <= 3'd4;
            end
            if (state == CMP) begin
                if (hit) begin
                    res[k] <= 1'b1;
                    glo    <= rom_q;
                end
                if (k != 3'd0) k <= k - 3'd1;
            end
            if (state == RCMP && up) res <= res + 5'd1;
            if (state == DONE && bus.out_ready) pix <= res;
        end
endmodule
